approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
- Synthesizable on-chip error-metric accumulator placed directly downstream of an approximate adder under test (e.g. the OLOCA k7 adder).
- Each accepted sample carries operands a, b and the adder's approximate sum. The block computes the exact sum itself.
- It accumulates error count, total error distance, maximum error distance and the nonzero-exact-sum count over a programmed number of samples.
- Host/testbench derives ER, MED, MRED denominator and NMED from these outputs after done.

Parameters:
N, 16, operand/sum width of the adder under test
CNT_W, 24, width of sample/error counters (covers 10,000,000 samples)
ACC_W, 40, width of error-distance accumulator (CNT_W+N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; clears results and begins a run
num_samples  in  CNT_W  samples to accept this run; sampled on start
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample this cycle
a  in  N  operand A of the sample
b  in  N  operand B of the sample
approx_sum  in  N  approximate adder sum output for (a,b)
busy  out  1  high in RUN and DRAIN
done  out  1  level, high in DONE until next start
sample_count  out  CNT_W  samples accumulated
err_count  out  CNT_W  samples with approx_sum != exact sum
nonzero_count  out  CNT_W  samples with exact sum != 0
ed_sum  out  ACC_W  sum of |approx_sum - exact_sum|, saturating
ed_max  out  N  maximum error distance seen

Behaviour:
- Reset: FSM=IDLE; in_ready=0, busy=0, done=0; all counters, ed_sum, ed_max=0; pipeline valid bits=0. Reset mid-run aborts with no partial results retained.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE/DONE + start: clear all result registers, latch num_samples, go to RUN. If num_samples==0, go directly to DONE next cycle with all results 0.
  - RUN: in_ready=1 while accepted<target. Transfer = in_valid&in_ready. On the transfer where accepted reaches target, go to DRAIN.
  - DRAIN: in_ready=0. When both pipeline stages are empty, go to DONE.
  - start is ignored in RUN and DRAIN.
- Arithmetic:
  - exact = (a+b) mod 2^N. Carry-out is not compared; errors are measured on the N-bit sum only.
  - ed = |approx_sum - exact| as unsigned N-bit magnitude.
- Pipeline, 2 stages:
  - S1 registers exact, ed and the nonzero flag on transfer.
  - S2 updates the accumulators from the S1 registers.
  - Results for a sample accepted at cycle t are visible at cycle t+2.
- S2 update when S1 valid:
  - sample_count+1.
  - err_count+1 if ed!=0.
  - nonzero_count+1 if exact!=0.
  - ed_sum+=ed, saturating at 2^ACC_W-1.
  - ed_max=max(ed_max, ed).
- done: asserts the cycle after the last sample's S2 update. sample_count==num_samples at done.
- Outputs remain stable in DONE until the next start.
- Back-to-back transfers every cycle are fully supported (throughput 1 sample/cycle). in_valid gaps do not corrupt results.
- in_valid while in_ready=0 is ignored, not buffered.

Decomposition:
- Package err_metric_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - default widths N_DEF=16, CNT_W_DEF=24, ACC_W_DEF=40
  - function abs_diff(x,y)
- Sub-module err_distance_stage (S1): combinational exact sum/abs-diff plus S1 registers, parameterized by N.
- The top module holds the FSM, counters and S2 accumulation.

Test Plan:
- Reset mid-run: start num_samples=100, drive 10 samples, deassert rst_n -> all outputs 0, state IDLE, in_ready=0.
- Single sample: start num_samples=1; a=0x00FF, b=0x0001, approx_sum=0x00FF -> done; err_count=1, ed_sum=1, ed_max=1, nonzero_count=1, sample_count=1.
- Wrap and zero: a=0xFFFF, b=0x0001, approx_sum=0x0000, num_samples=1 -> exact=0; err_count=0, nonzero_count=0, ed_sum=0.
- Max/abs tracking: 3 samples with exact 0x1000 and approx 0x1010, 0x0F00, 0x1000 -> ed_sum=0x0110, ed_max=0x0100, err_count=2.
- Handshake: num_samples=4, in_valid held high for 6 cycles -> exactly 4 transfers, in_ready low after 4th, done 3 cycles after 4th transfer. Repeat with in_valid toggling every other cycle -> identical results.
- num_samples=0: start -> DONE next cycle, all results 0. Start asserted during RUN -> ignored; a second start in DONE -> results clear to 0 next cycle.

Source files
------------

// File: rtl/err_metric_pkg.sv
// Shared types, default widths and helpers for the approximate-adder error monitor.
package err_metric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int N_DEF     = 16;
  localparam int CNT_W_DEF = 24;
  localparam int ACC_W_DEF = 40;

  // abs_diff works on a fixed wide word; callers zero-extend and truncate.
  localparam int ABS_W = 32;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/err_distance_stage.sv
// S1: exact N-bit sum, error distance against the approximate sum, registered on transfer.
module err_distance_stage
  import err_metric_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_approx,
  output logic         o_valid,
  output logic [N-1:0] o_ed,
  output logic         o_nonzero
);

  logic [N-1:0] w_exact;
  logic [N-1:0] w_ed;
  logic         w_nonzero;

  logic         r_valid;
  logic [N-1:0] r_ed;
  logic         r_nonzero;

  // Carry-out is dropped on purpose: only the N-bit sum is compared.
  assign w_exact   = i_a + i_b;
  assign w_ed      = N'(abs_diff(ABS_W'(i_approx), ABS_W'(w_exact)));
  assign w_nonzero = (w_exact != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ed      <= '0;
      r_nonzero <= 1'b0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_ed      <= w_ed;
        r_nonzero <= w_nonzero;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_ed      = r_ed;
  assign o_nonzero = r_nonzero;

endmodule

// File: rtl/approx_err_monitor.sv
// Error-metric accumulator for an approximate adder: run FSM, sample handshake and S2 accumulation.
module approx_err_monitor
  import err_metric_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] nonzero_count,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     ed_max
);

  localparam int ACC_X = ACC_W + 1;

  state_e r_state;
  state_e w_state_next;

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_nonzero_count;
  logic [ACC_W-1:0] r_ed_sum;
  logic [N-1:0]     r_ed_max;

  logic             w_start_accept;
  logic             w_transfer;
  logic             w_last;
  logic             w_s1_valid;
  logic [N-1:0]     w_s1_ed;
  logic             w_s1_nonzero;
  logic [ACC_X-1:0] w_sum_ext;
  logic [ACC_W-1:0] w_ed_sum_next;

  assign w_start_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_transfer     = in_valid && in_ready;
  assign w_last         = w_transfer && ((r_accepted + CNT_W'(1)) == r_target);

  err_distance_stage #(
    .N(N)
  ) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_transfer),
    .i_a      (a),
    .i_b      (b),
    .i_approx (approx_sum),
    .o_valid  (w_s1_valid),
    .o_ed     (w_s1_ed),
    .o_nonzero(w_s1_nonzero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The accumulators are the S2 register, so an empty S1 means all updates landed.
        if (!w_s1_valid) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      RUN: begin
        in_ready = (r_accepted < r_target);
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Saturating add: one extra bit catches the overflow.
  assign w_sum_ext     = {1'b0, r_ed_sum} + ACC_X'(w_s1_ed);
  assign w_ed_sum_next = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target        <= '0;
      r_accepted      <= '0;
      r_sample_count  <= '0;
      r_err_count     <= '0;
      r_nonzero_count <= '0;
      r_ed_sum        <= '0;
      r_ed_max        <= '0;
    end else if (w_start_accept) begin
      r_target        <= num_samples;
      r_accepted      <= '0;
      r_sample_count  <= '0;
      r_err_count     <= '0;
      r_nonzero_count <= '0;
      r_ed_sum        <= '0;
      r_ed_max        <= '0;
    end else begin
      if (w_transfer) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
      if (w_s1_valid) begin
        r_sample_count <= r_sample_count + CNT_W'(1);
        if (w_s1_ed != '0) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        if (w_s1_nonzero) begin
          r_nonzero_count <= r_nonzero_count + CNT_W'(1);
        end
        r_ed_sum <= w_ed_sum_next;
        if (w_s1_ed > r_ed_max) begin
          r_ed_max <= w_s1_ed;
        end
      end
    end
  end

  assign sample_count  = r_sample_count;
  assign err_count     = r_err_count;
  assign nonzero_count = r_nonzero_count;
  assign ed_sum        = r_ed_sum;
  assign ed_max        = r_ed_max;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with a per-run expected-result scoreboard.
module tb_approx_err_monitor;

  localparam int N     = 16;
  localparam int CNT_W = 24;
  localparam int ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     approx_sum;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] nonzero_count;
  logic [ACC_W-1:0] ed_sum;
  logic [N-1:0]     ed_max;

  always #5 clk = ~clk;

  approx_err_monitor #(
    .N    (N),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .nonzero_count(nonzero_count),
    .ed_sum       (ed_sum),
    .ed_max       (ed_max)
  );

  typedef struct {
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] nz;
    logic [ACC_W-1:0] es;
    logic [N-1:0]     em;
  } res_t;

  res_t exp_q[$];
  res_t m;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [N-1:0] da [4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
  logic [N-1:0] db [4] = '{16'h1111, 16'h0001, 16'h8000, 16'h0002};
  logic [N-1:0] dap[4] = '{16'h2345, 16'h0005, 16'h0100, 16'h0002};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m.sc = '0; m.ec = '0; m.nz = '0; m.es = '0; m.em = '0;
  endtask

  task automatic model_add(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic [N-1:0] xap);
    logic [N-1:0] ex;
    logic [N-1:0] ed;
    ex = xa + xb;
    ed = (xap >= ex) ? (xap - ex) : (ex - xap);
    m.sc++;
    if (ed != 0) m.ec++;
    if (ex != 0) m.nz++;
    m.es = m.es + ACC_W'(ed);
    if (ed > m.em) m.em = ed;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    model_reset();
  endtask

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic [N-1:0] xap);
    int k;
    a = xa; b = xb; approx_sum = xap;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_ready_timeout", 64'(in_ready), 64'd1);
    else model_add(xa, xb, xap);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_results(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sample_count"}, 64'(sample_count), 64'(e.sc));
      chk({tag, "_err_count"}, 64'(err_count), 64'(e.ec));
      chk({tag, "_nonzero_count"}, 64'(nonzero_count), 64'(e.nz));
      chk({tag, "_ed_sum"}, 64'(ed_sum), 64'(e.es));
      chk({tag, "_ed_max"}, 64'(ed_max), 64'(e.em));
      $display("run %s: samples=%0d errs=%0d nonzero=%0d ed_sum=%0h ed_max=%0h",
               tag, sample_count, err_count, nonzero_count, ed_sum, ed_max);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample_count"}, 64'(sample_count), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_nonzero_count"}, 64'(nonzero_count), 64'd0);
    chk({tag, "_ed_sum"}, 64'(ed_sum), 64'd0);
    chk({tag, "_ed_max"}, 64'(ed_max), 64'd0);
  endtask

  task automatic run_hs(input bit toggle, input string tag);
    int xfers;
    int last;
    int idx;
    logic vld;
    do_start(4);
    xfers = 0;
    last = -100;
    for (int c = 0; c < 14; c++) begin
      vld = toggle ? (c % 2 == 0) : (c < 6);
      idx = (xfers < 4) ? xfers : 3;
      in_valid = vld;
      a = da[idx]; b = db[idx]; approx_sum = dap[idx];
      if (c == last + 1) chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
      if (c == last + 2) chk({tag, "_done_early"}, 64'(done), 64'd0);
      if (c == last + 3) chk({tag, "_done_at_3"}, 64'(done), 64'd1);
      if (vld && in_ready) begin
        model_add(da[idx], db[idx], dap[idx]);
        $display("xfer %s: a=%h b=%h approx=%h", tag, da[idx], db[idx], dap[idx]);
        xfers++;
        if (xfers == 4) last = c;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_xfers"}, 64'(xfers), 64'd4);
    exp_q.push_back(m);
    check_results(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    check_zero("reset");

    // Reset mid-run discards everything.
    do_start(100);
    for (int i = 0; i < 10; i++) send(N'(i * 7), N'(i + 1), N'(i * 3));
    @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    chk("midrun_count", 64'(sample_count), 64'(m.sc));
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 64'(in_ready), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    check_zero("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_ready", 64'(in_ready), 64'd0);
    chk("after_rst_done", 64'(done), 64'd0);
    check_zero("after_rst");

    do_start(1);
    send(16'h00FF, 16'h0001, 16'h00FF);
    exp_q.push_back(m);
    wait_done("single");
    check_results("single");

    do_start(1);
    send(16'hFFFF, 16'h0001, 16'h0000);
    exp_q.push_back(m);
    wait_done("wrap");
    check_results("wrap");

    do_start(3);
    send(16'h0800, 16'h0800, 16'h1010);
    send(16'h0800, 16'h0800, 16'h0F00);
    send(16'h0800, 16'h0800, 16'h1000);
    exp_q.push_back(m);
    wait_done("maxabs");
    check_results("maxabs");

    run_hs(1'b0, "hs_held");
    run_hs(1'b1, "hs_toggle");

    do_start(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_ready", 64'(in_ready), 64'd0);
    check_zero("zero");

    // A start during RUN must not restart or retarget the run.
    do_start(2);
    send(16'h0010, 16'h0020, 16'h0031);
    start = 1'b1;
    num_samples = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    chk("run_start_busy", 64'(busy), 64'd1);
    send(16'h0100, 16'h0200, 16'h0300);
    exp_q.push_back(m);
    wait_done("run_start");
    check_results("run_start");

    do_start(3);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    check_zero("restart");
    send(16'h4000, 16'h4000, 16'h7FFF);
    send(16'h0000, 16'h0000, 16'h0000);
    send(16'h1234, 16'h4321, 16'h5555);
    exp_q.push_back(m);
    wait_done("restart_run");
    check_results("restart_run");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
